// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: redirect encoding and the
// address-width / wrap-increment helpers used by the PC and return stack.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_JMP,
        REDIR_CALL,
        REDIR_RET
    } redir_t;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Anything at or past the last word wraps to 0, so non-power-of-2 ROMs work
    function automatic logic [31:0] wrap_inc(input logic [31:0] x, input int n);
        return (x >= 32'(n - 1)) ? 32'd0 : x + 32'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_ret_stack.sv
// Return-address LIFO for call/ret; overflowing pushes and underflowing pops
// are dropped and recorded in sticky flags.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         ovf,
    output logic         unf
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]   mem [2**IDXW];
    logic [SPW-1:0] sp;
    logic           full;

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);
    assign top   = mem[IDXW'(sp - SPW'(1))];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            for (int i = 0; i < 2**IDXW; i++) begin
                mem[i] <= '0;
            end
        end else if (pop) begin
            if (!empty) begin
                sp <= sp - SPW'(1);
            end else begin
                unf <= 1'b1;
            end
        end else if (push) begin
            if (!full) begin
                mem[IDXW'(sp)] <= push_data;
                sp             <= sp + SPW'(1);
            end else begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Program counter and fetch stage in front of a registered-read ROM, with
// stall, jump and call/return redirects that insert no bubble.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter  int NADDRE    = 8,
    parameter  int NBDATA    = 12,
    parameter  int RST_ADDR  = 0,
    parameter  int STK_DEPTH = 4,
    localparam int AW        = addr_width(NADDRE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jmp_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic [AW-1:0]     jmp_addr,
    output logic [AW-1:0]     mem_addr,
    input  logic [NBDATA-1:0] mem_data,
    output logic [NBDATA-1:0] instr,
    output logic [AW-1:0]     instr_pc,
    output logic              instr_vld,
    output logic              stk_ovf,
    output logic              stk_unf
);

    localparam logic [AW-1:0] RST_PC = AW'(RST_ADDR);

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_d1;
    logic          vld_d1;
    redir_t        redir;
    logic [AW-1:0] raw_target;
    logic [AW-1:0] target;
    logic [AW-1:0] target_inc;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] ret_addr;
    logic [AW-1:0] stk_top;
    logic          stk_empty;

    assign instr     = mem_data;
    assign instr_pc  = pc_d1;
    assign instr_vld = vld_d1;

    assign pc_inc     = AW'(wrap_inc(32'(pc), NADDRE));
    assign ret_addr   = AW'(wrap_inc(32'(pc_d1), NADDRE));
    assign target_inc = AW'(wrap_inc(32'(target), NADDRE));

    // Redirects only act on a valid instruction; ret beats call beats jmp
    always_comb begin
        redir = REDIR_NONE;
        if (vld_d1) begin
            if (ret_en) begin
                redir = REDIR_RET;
            end else if (call_en) begin
                redir = REDIR_CALL;
            end else if (jmp_en) begin
                redir = REDIR_JMP;
            end
        end
    end

    always_comb begin
        raw_target = jmp_addr;
        if (redir == REDIR_RET) begin
            raw_target = stk_empty ? RST_PC : stk_top;
        end
        target = (32'(raw_target) >= 32'(NADDRE)) ? '0 : raw_target;
    end

    // On stall the ROM re-reads the displayed address so instr stays put
    always_comb begin
        mem_addr = stall ? pc_d1 : pc;
        if (redir != REDIR_NONE) begin
            mem_addr = target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RST_PC;
            pc_d1  <= RST_PC;
            vld_d1 <= 1'b0;
        end else if (redir != REDIR_NONE) begin
            pc     <= target_inc;
            pc_d1  <= target;
            vld_d1 <= 1'b1;
        end else if (!stall) begin
            pc     <= pc_inc;
            pc_d1  <= pc;
            vld_d1 <= 1'b1;
        end
    end

    ret_stack #(
        .DEPTH (STK_DEPTH),
        .W     (AW)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (redir == REDIR_CALL),
        .pop       (redir == REDIR_RET),
        .push_data (ret_addr),
        .top       (stk_top),
        .empty     (stk_empty),
        .ovf       (stk_ovf),
        .unf       (stk_unf)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch/stall/jump/call/ret
// vectors push expected instr_pc values; a negedge monitor checks them.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jmp_en;
    logic        call_en;
    logic        ret_en;
    logic [2:0]  jmp_addr;
    logic [2:0]  mem_addr;
    logic [11:0] mem_data;
    logic [11:0] instr;
    logic [2:0]  instr_pc;
    logic        instr_vld;
    logic        stk_ovf;
    logic        stk_unf;

    logic [11:0] rom [8];
    logic [2:0]  sb [$];
    logic [2:0]  mon_pc;
    int          checks = 0;
    int          errors = 0;

    instr_fetch #(
        .NADDRE    (8),
        .NBDATA    (12),
        .RST_ADDR  (0),
        .STK_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .jmp_en    (jmp_en),
        .call_en   (call_en),
        .ret_en    (ret_en),
        .jmp_addr  (jmp_addr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .instr     (instr),
        .instr_pc  (instr_pc),
        .instr_vld (instr_vld),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data <= rom[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Entered just after a rising edge; drives one cycle of inputs and queues
    // the instr_pc expected to be displayed in the following cycle.
    task automatic applyStimulus(input logic s, input logic j, input logic c, input logic r,
                                 input logic [2:0] a, input logic [2:0] exp_addr,
                                 input bit exp_push, input logic [2:0] exp_pc);
        stall    = s;
        jmp_en   = j;
        call_en  = c;
        ret_en   = r;
        jmp_addr = a;
        if (exp_push) begin
            sb.push_back(exp_pc);
        end
        #1;
        checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && instr_vld === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got instr_pc %0h with nothing expected at %0t", instr_pc, $time);
            end else begin
                mon_pc = sb.pop_front();
                checkOutput("instr_pc", 32'(instr_pc), 32'(mon_pc));
                checkOutput("instr", 32'(instr), 32'(rom[mon_pc]));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            rom[i] = 12'hA5C ^ (12'(i) * 12'h123);
        end
        rst      = 1'b0;
        stall    = 1'b0;
        jmp_en   = 1'b0;
        call_en  = 1'b0;
        ret_en   = 1'b0;
        jmp_addr = '0;

        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_vld", 32'(instr_vld), 0);
        checkOutput("rst_instr_pc", 32'(instr_pc), 0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 0);
        checkOutput("rst_ovf", 32'(stk_ovf), 0);
        checkOutput("rst_unf", 32'(stk_unf), 0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("first_cycle_vld", 32'(instr_vld), 0);

        // Sequential fetch then a 3-cycle stall at address 2
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 2, 1, 2);
        applyStimulus(1, 0, 0, 0, 0, 2, 1, 2);
        applyStimulus(1, 0, 0, 0, 0, 2, 1, 2);
        applyStimulus(1, 0, 0, 0, 0, 2, 1, 2);
        applyStimulus(0, 0, 0, 0, 0, 3, 1, 3);
        applyStimulus(0, 0, 0, 0, 0, 4, 1, 4);

        // Jumps, including wrap from 7 to 0
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 1);
        applyStimulus(0, 1, 0, 0, 6, 6, 1, 6);
        applyStimulus(0, 0, 0, 0, 0, 7, 1, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 2, 1, 2);

        // Call/ret, then call+ret together acting as ret
        applyStimulus(0, 0, 1, 0, 5, 5, 1, 5);
        applyStimulus(0, 0, 0, 0, 0, 6, 1, 6);
        applyStimulus(0, 0, 0, 1, 0, 3, 1, 3);
        applyStimulus(0, 0, 1, 0, 7, 7, 1, 7);
        applyStimulus(0, 0, 1, 1, 2, 4, 1, 4);
        checkOutput("ovf_clear", 32'(stk_ovf), 0);
        checkOutput("unf_clear", 32'(stk_unf), 0);
        applyStimulus(0, 0, 0, 0, 0, 5, 1, 5);

        // Five nested calls: the fifth return address is dropped
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0, 1, 1, 1, 1);
        applyStimulus(0, 0, 1, 0, 2, 2, 1, 2);
        applyStimulus(0, 0, 1, 0, 3, 3, 1, 3);
        checkOutput("ovf_at_full", 32'(stk_ovf), 0);
        applyStimulus(0, 0, 1, 0, 6, 6, 1, 6);
        checkOutput("ovf_set", 32'(stk_ovf), 1);
        checkOutput("unf_still_clear", 32'(stk_unf), 0);
        applyStimulus(0, 0, 0, 0, 0, 7, 1, 7);
        applyStimulus(0, 0, 0, 1, 0, 3, 1, 3);
        applyStimulus(0, 0, 0, 1, 0, 2, 1, 2);
        applyStimulus(0, 0, 0, 1, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 1, 0, 6, 1, 6);
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("unf_set", 32'(stk_unf), 1);
        checkOutput("ovf_sticky", 32'(stk_ovf), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);

        // Two calls deep, stall, then reset mid-stall
        applyStimulus(0, 0, 1, 0, 4, 4, 1, 4);
        applyStimulus(0, 0, 1, 0, 3, 3, 1, 3);
        applyStimulus(1, 0, 0, 0, 0, 3, 1, 3);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_vld", 32'(instr_vld), 0);
        checkOutput("midrst_instr_pc", 32'(instr_pc), 0);
        checkOutput("midrst_mem_addr", 32'(mem_addr), 0);
        checkOutput("midrst_ovf", 32'(stk_ovf), 0);
        checkOutput("midrst_unf", 32'(stk_unf), 0);
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("restart_vld", 32'(instr_vld), 0);

        // Jump while invalid is ignored; ret proves the stack was emptied
        applyStimulus(0, 1, 0, 0, 5, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 0);
        checkOutput("restart_unf", 32'(stk_unf), 1);
        checkOutput("restart_ovf", 32'(stk_ovf), 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);

        @(negedge clk);
        #1;
        checkOutput("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Program-counter and fetch stage that sits directly upstream of the synchronous instruction ROM (registered read, 1-cycle latency). It drives the ROM address and presents each returned word together with its address and a valid flag to decode/execute. It handles stalls, jumps, and call/return through a small return-address stack, with zero-bubble redirects.

Parameters:
NADDRE, 8, number of instruction words in the ROM; address width AW = $clog2(NADDRE)
NBDATA, 12, instruction word width
RST_ADDR, 0, first address fetched after reset
STK_DEPTH, 4, return-stack entries (≥1)

Ports:
clk  in  1  clock, all registers on rising edge
rst  in  1  reset, asynchronous, active-low
stall  in  1  hold the current instruction
jmp_en  in  1  redirect to jmp_addr
call_en  in  1  redirect to jmp_addr and push the return address
ret_en  in  1  redirect to the popped return address
jmp_addr  in  AW  jump/call target
mem_addr  out  AW  ROM address, combinational
mem_data  in  NBDATA  ROM registered read data
instr  out  NBDATA  current instruction (= mem_data)
instr_pc  out  AW  address of instr
instr_vld  out  1  instr is valid
stk_ovf  out  1  sticky: push attempted while stack full
stk_unf  out  1  sticky: pop attempted while stack empty

Behaviour:
- Registers: pc (next sequential address), pc_d1 (address whose data is on mem_data), vld_d1, stack[STK_DEPTH], sp (0..STK_DEPTH), stk_ovf, stk_unf.
- Reset (async, rst=0): pc=RST_ADDR, pc_d1=RST_ADDR, vld_d1=0, sp=0, flags=0. Outputs during reset: mem_addr=RST_ADDR, instr_vld=0, instr_pc=RST_ADDR, stk_ovf=stk_unf=0. Release mid-operation restarts cleanly at RST_ADDR.
- instr=mem_data; instr_pc=pc_d1; instr_vld=vld_d1.
- inc(x) = x+1, or 0 when x=NADDRE-1 (NADDRE need not be a power of 2). Targets ≥NADDRE are replaced by 0.
- Redirects take effect only when instr_vld=1; otherwise they are ignored. Priority: ret_en > call_en > jmp_en. call_en and jmp_en together behave as call_en. ret_en and call_en together behave as ret_en, with no push.
- Target T: ret uses stack[sp-1] (RST_ADDR if empty); call and jmp use jmp_addr.
- mem_addr mux: redirect ? T : (stall ? pc_d1 : pc).
- Per edge:
  - Redirect (overrides stall): pc<=inc(T), pc_d1<=T, vld_d1<=1. The next cycle shows the target instruction, so there is no bubble.
  - Else stall: pc, pc_d1 and vld_d1 hold. The ROM re-reads pc_d1, so instr stays stable for any stall length.
  - Else: pc<=inc(pc), pc_d1<=pc, vld_d1<=1.
- First cycle after reset: instr_vld=0 and mem_addr=RST_ADDR. The next cycle shows instr_pc=RST_ADDR with instr_vld=1. A stall in that first cycle holds vld_d1=0.
- Call: push inc(pc_d1) when sp<STK_DEPTH, sp++. When full, no push, stack unchanged, stk_ovf<=1.
- Ret: when sp>0, pop and sp--. When empty, target RST_ADDR and stk_unf<=1.
- Flags clear only on reset.
- The mem_addr path is combinational from jmp_en, call_en, ret_en and stall. This is accepted; the ROM registers it.

Decomposition:
- Shared package: AW computation helper, a wrap-increment function, redirect-select encoding (NONE/JMP/CALL/RET).
- One sub-module, ret_stack: a LIFO with push/pop, top output, full/empty, and ovf/unf flags, with the same clk/rst.

Test Plan:
- Reset, NADDRE=8: release rst → cycle0 mem_addr=0, instr_vld=0. Then instr_pc = 0,1,2,… each cycle, all valid, with instr = ROM contents.
- Stall 3 cycles while instr_pc=2 → instr_pc=2 and instr unchanged for 3 cycles, mem_addr=2. After release, instr_pc goes 3,4.
- Jump: jmp_en with jmp_addr=6 while instr_pc=1 → next cycle instr_pc=6 valid, then 7, then 0 (wrap). jmp_en with instr_vld=0 has no effect.
- Call/ret: call_en to 5 at instr_pc=2 → instr_pc 5,6. ret_en at 6 → next instr_pc=3. Simultaneous call+ret → behaves as ret.
- Stack bounds, STK_DEPTH=4: five nested calls → stk_ovf=1 and the 5th return address is dropped. Ret on empty stack → instr_pc=RST_ADDR and stk_unf=1.
- Reset mid-stall with sp=2 → all outputs return to reset values immediately, without a clock edge. After release, fetch restarts at 0 with sp=0.
